ca6_seq_multiplier_top: RTL and testbench



---
 rtl/ca6_seq_multiplier_top.sv | 123 ++++++++++++
 tb/tb_ca6_seq_multiplier_top.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ca6_seq_multiplier_top.sv
// Purpose : sequential shift-add multiplier, unsigned Q0.24 x Q0.24 -> truncated Q0.24.
// Latency : start sampled at E0, doneMul high after E24, result valid from E25 on.
// Backpress: none; a level start is taken once, and HOLD waits for the request to drop.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset, clears all state and aborts a run
//   startMul - level start request, sampled only in IDLE (and for the DONE/HOLD exit)
//   A, B     - multiplicand / multiplier, captured on the start edge only
//   result   - registered product[47:24], held until the next DONE
//   doneMul  - one-cycle completion pulse (high while the FSM is in DONE)

module ca6_seq_multiplier_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        startMul,
  input  logic [23:0] A,
  input  logic [23:0] B,
  output logic [23:0] result,
  output logic        doneMul
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'd23;

  state_t      state_q,  state_d;
  logic [23:0] mc_q,     mc_d;
  logic [24:0] acc_q,    acc_d;
  logic [23:0] mq_q,     mq_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [23:0] result_q, result_d;
  logic        done_q,   done_d;

  // Partial sum for the current step: add MC only when the multiplier LSB is set.
  // Both operands are below 2^24 in bit 24 terms, so 25 bits always hold the carry.
  logic [24:0] sum;

  always_comb begin
    sum = acc_q + (mq_q[0] ? {1'b0, mc_q} : 25'd0);
  end

  always_comb begin
    state_d  = state_q;
    mc_d     = mc_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (startMul) begin
          mc_d    = A;
          mq_d    = B;
          acc_d   = 25'd0;
          cnt_d   = 5'd0;
          state_d = CALC;
        end
      end

      CALC: begin
        // {ACC,MQ} shifted right as a single 49-bit value: the carry out of the
        // add lands in ACC[23], and the bit leaving ACC enters the top of MQ.
        acc_d = {1'b0, sum[24:1]};
        mq_d  = {sum[0], mq_q[23:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // After 24 steps ACC holds product[47:24]; MQ holds the discarded low half.
        result_d = acc_q[23:0];
        state_d  = startMul ? HOLD : IDLE;
      end

      HOLD: begin
        // Block an automatic restart until the requester drops startMul.
        if (!startMul) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered Moore output: high exactly for the cycle spent in DONE.
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mc_q     <= 24'd0;
      acc_q    <= 25'd0;
      mq_q     <= 24'd0;
      cnt_q    <= 5'd0;
      result_q <= 24'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_q     <= mc_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result  = result_q;
  assign doneMul = done_q;

endmodule

// File: tb/tb_ca6_seq_multiplier_top.sv
// Purpose : randomized self-checking bench for ca6_seq_multiplier_top.
// Latency : expects doneMul one sample after edge E24, result stable from E25.
// Backpress: drives start levels of various lengths, including holds beyond the run.

module tb_ca6_seq_multiplier_top;

  logic        clk;
  logic        rst;
  logic        start_mul;
  logic [23:0] a_in;
  logic [23:0] b_in;
  logic [23:0] result;
  logic        done_mul;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] prev_res;

  ca6_seq_multiplier_top dut (
    .clk      (clk),
    .rst      (rst),
    .startMul (start_mul),
    .A        (a_in),
    .B        (b_in),
    .result   (result),
    .doneMul  (done_mul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact 48-bit product, keep the upper 24 bits (truncated Q0.24).
  function automatic logic [23:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] p;
    p = 48'(a) * 48'(b);
    return p[47:24];
  endfunction

  // One operation: start is raised before edge E0 and held for 'hold' edges.
  // If chg_cyc > 0 the operands are scrambled after that many edges.
  task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input int hold, input int chg_cyc);
    logic [23:0] exp;
    int pulses;
    int first_pulse;
    int window;
    exp = ref_mul(a, b);
    pulses = 0;
    first_pulse = -1;
    window = (hold > 30) ? hold + 6 : 32;
    @(negedge clk);
    a_in = a;
    b_in = b;
    start_mul = 1'b1;
    for (int cyc = 0; cyc <= window; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc > 0 && done_mul === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = cyc;
      end
      if (cyc == 10) chk({tag, "_retain"}, 48'(result), 48'(prev_res));
      if (cyc == 25) chk({tag, "_res_e25"}, 48'(result), 48'(exp));
      if (cyc + 1 == hold) start_mul = 1'b0;
      if (chg_cyc > 0 && cyc == chg_cyc) begin
        a_in = 24'($urandom);
        b_in = 24'($urandom);
      end
    end
    start_mul = 1'b0;
    chk({tag, "_pulses"}, 48'(pulses), 48'd1);
    chk({tag, "_pulse_cyc"}, 48'(first_pulse), 48'd24);
    chk({tag, "_res_end"}, 48'(result), 48'(exp));
    prev_res = exp;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int idle_pulses;
    int abort_pulses;
    logic [23:0] ra;
    logic [23:0] rb;

    rst = 1'b1;
    start_mul = 1'b0;
    a_in = 24'd0;
    b_in = 24'd0;
    prev_res = 24'd0;
    #20;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_result", 48'(result), 48'd0);
    chk("rst_done", 48'(done_mul), 48'd0);
    idle_pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done_mul !== 1'b0) idle_pulses++;
    end
    chk("idle_no_pulse", 48'(idle_pulses), 48'd0);
    chk("idle_result", 48'(result), 48'd0);

    run_op("basic",   24'h400000, 24'h400000, 20, 0);
    chk("basic_val", 48'(result), 48'h100000);
    run_op("full",    24'hFFFFFF, 24'hFFFFFF, 12, 0);
    chk("full_val", 48'(result), 48'hFFFFFE);
    run_op("half",    24'h800000, 24'h800000, 12, 0);
    chk("half_val", 48'(result), 48'h400000);
    run_op("trunc",   24'hFFFFFF, 24'h000001, 12, 0);
    chk("trunc_val", 48'(result), 48'h000000);
    run_op("zero",    24'h000000, 24'($urandom), 5, 0);
    run_op("stable",  24'h400000, 24'h400000, 12, 3);
    chk("stable_val", 48'(result), 48'h100000);

    for (int i = 0; i < 3; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, 12, 0);
      repeat (30) @(posedge clk);
    end

    // Abort: reset arrives after CALC step 10 and must clear result with no pulse.
    @(negedge clk);
    a_in = 24'($urandom);
    b_in = 24'($urandom);
    start_mul = 1'b1;
    abort_pulses = 0;
    for (int cyc = 0; cyc <= 10; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc > 0 && done_mul === 1'b1) abort_pulses++;
      if (cyc == 5) start_mul = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("abort_result", 48'(result), 48'd0);
    chk("abort_done", 48'(done_mul), 48'd0);
    #19;
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done_mul !== 1'b0) abort_pulses++;
    end
    chk("abort_no_pulse", 48'(abort_pulses), 48'd0);
    chk("abort_result_post", 48'(result), 48'd0);
    prev_res = 24'd0;
    ra = 24'($urandom);
    rb = 24'($urandom);
    run_op("after_abort", ra, rb, 8, 0);

    // Long hold: one pulse only, then a fresh start must still work.
    run_op("hold60", 24'($urandom), 24'($urandom), 60, 0);
    ra = 24'($urandom);
    rb = 24'($urandom);
    run_op("after_hold", ra, rb, 1, 0);

    for (int i = 0; i < 4; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      run_op($sformatf("mix%0d", i), ra, rb, int'($urandom_range(1, 40)), int'($urandom_range(0, 20)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
